// File: rtl/sid_pkg.sv
// Shared SID package: cycle phase type and pot scheduler state encoding.
package sid;

  typedef logic [1:0] cycle_t;

  localparam cycle_t CYCLE_PHI1 = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DISCH,
    MEASURE,
    NEXT
  } pot_sched_state_t;

  localparam logic [7:0] POT_MEAS_MAX = 8'hFF;

endpackage

// File: rtl/sid_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sid_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give metastability a full clock to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sid_pot_sched.sv
// Time-multiplexed paddle (POT) acquisition scheduler sharing one discharge
// transistor and one comparator across N_CH channels via an analog mux.
// Optional: define SID_POT_SCHED_AVG_EN to average each new sample with the
// previous value of the channel (first sample after reset is stored raw).
module sid_pot_sched
  import sid::*;
#(
  parameter int N_CH          = 4,
  parameter int DISCH_CYCLES  = 256,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  cycle_t                     cycle,
  input  logic                       enable,
  input  logic [N_CH-1:0]            ch_mask,
  input  logic                       charged,
  output logic [$clog2(N_CH)-1:0]    mux_sel,
  output logic                       discharge,
  output logic [N_CH-1:0][7:0]       pot,
  output logic [N_CH-1:0]            pot_valid,
  output logic                       round_done
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [9:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 10'd0 : 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] DISCH_LAST  = 10'(DISCH_CYCLES - 1);

  typedef logic [SEL_W-1:0] sel_t;

  pot_sched_state_t       state_q, state_d;
  sel_t                   sel_q, sel_d;
  logic [9:0]             cnt_q, cnt_d;
  logic [7:0]             meas_q, meas_d;
  logic [N_CH-1:0][7:0]   pot_q, pot_d;
  logic [N_CH-1:0]        valid_q, valid_d;
  logic                   round_q, round_d;
  logic                   charged_s;
  logic                   tick;
  logic [SEL_W:0]         lowHit;
  logic [SEL_W:0]         nextHit;

`ifdef SID_POT_SCHED_AVG_EN
  logic [N_CH-1:0]        primed_q, primed_d;

  function automatic logic [7:0] avgOf(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction
`endif

  // Lowest set mask bit at or above start; MSB of the result flags a hit.
  function automatic logic [SEL_W:0] findFrom(input logic [N_CH-1:0] mask, input int start);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) res = {1'b1, sel_t'(i)};
    end
    return res;
  endfunction

  sid_sync2 #(.WIDTH(1)) u_charged_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (charged),
    .q_o   (charged_s)
  );

  assign tick    = (cycle == CYCLE_PHI1);
  assign lowHit  = findFrom(ch_mask, 0);
  assign nextHit = findFrom(ch_mask, int'(sel_q) + 1);

  // Scheduler next-state: every decision waits for a phi1 tick, strobes default low.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    meas_d  = meas_q;
    pot_d   = pot_q;
    valid_d = '0;
    round_d = 1'b0;
`ifdef SID_POT_SCHED_AVG_EN
    primed_d = primed_q;
`endif
    if (tick) begin
      if (!enable && (state_q == SETTLE || state_q == DISCH || state_q == MEASURE)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (enable && lowHit[SEL_W]) begin
              sel_d   = lowHit[SEL_W-1:0];
              cnt_d   = '0;
              state_d = SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_q >= SETTLE_LAST) begin
              cnt_d   = '0;
              state_d = DISCH;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          DISCH: begin
            if (cnt_q >= DISCH_LAST) begin
              cnt_d   = '0;
              meas_d  = '0;
              state_d = MEASURE;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          MEASURE: begin
            if (charged_s || meas_q == POT_MEAS_MAX) begin
`ifdef SID_POT_SCHED_AVG_EN
              pot_d[sel_q]    = primed_q[sel_q] ? avgOf(pot_q[sel_q], meas_q) : meas_q;
              primed_d[sel_q] = 1'b1;
`else
              pot_d[sel_q] = meas_q;
`endif
              valid_d[sel_q] = 1'b1;
              state_d        = NEXT;
            end else begin
              meas_d = meas_q + 8'd1;
            end
          end
          NEXT: begin
            cnt_d = '0;
            if (nextHit[SEL_W]) begin
              sel_d   = nextHit[SEL_W-1:0];
              state_d = enable ? SETTLE : IDLE;
            end else begin
              round_d = 1'b1;
              if (enable && lowHit[SEL_W]) begin
                sel_d   = lowHit[SEL_W-1:0];
                state_d = SETTLE;
              end else begin
                state_d = IDLE;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State, counters, position registers and strobes; reset parks the cap discharged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      meas_q  <= '0;
      pot_q   <= '0;
      valid_q <= '0;
      round_q <= 1'b0;
`ifdef SID_POT_SCHED_AVG_EN
      primed_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      pot_q   <= pot_d;
      valid_q <= valid_d;
      round_q <= round_d;
`ifdef SID_POT_SCHED_AVG_EN
      primed_q <= primed_d;
`endif
    end
  end

  assign mux_sel    = sel_q;
  assign discharge  = (state_q != MEASURE);
  assign pot        = pot_q;
  assign pot_valid  = valid_q;
  assign round_done = round_q;

endmodule

// File: tb/tb_sid_pot_sched.sv
// Testbench for sid_pot_sched: randomized charge times, reference model of the
// round-robin measurement sequence, scoreboard queue drained by a monitor.
module tb_sid_pot_sched;

  typedef struct {
    bit         isRound;
    int         ch;
    logic [7:0] val;
  } evt_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  sid::cycle_t      cycle = '0;
  logic             enable = 1'b0;
  logic [3:0]       ch_mask = '0;
  logic             charged = 1'b0;
  logic [1:0]       mux_sel;
  logic             discharge;
  logic [3:0][7:0]  pot;
  logic [3:0]       pot_valid;
  logic             round_done;

  int         checks = 0;
  int         errors = 0;
  int         tickCount = 0;
  evt_t       sbQ[$];
  evt_t       monEvt;
  logic [7:0] potModel[4];
  bit         primedModel[4];
  logic [3:0] prevValid = '0;
  logic       prevRound = 1'b0;
  bit         muxCheckOn = 0;
  logic [3:0] muxAllowed = 4'b1010;
  int         muxViol = 0;

  sid_pot_sched #(
    .N_CH          (4),
    .DISCH_CYCLES  (256),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cycle      (cycle),
    .enable     (enable),
    .ch_mask    (ch_mask),
    .charged    (charged),
    .mux_sel    (mux_sel),
    .discharge  (discharge),
    .pot        (pot),
    .pot_valid  (pot_valid),
    .round_done (round_done)
  );

  initial forever #5 clk = ~clk;

  // phi1 ticks arrive every 4 or 5 clocks, with a random gap length
  initial begin
    forever begin
      @(negedge clk); cycle = 2'd1;
      @(negedge clk); cycle = 2'd2;
      @(negedge clk); cycle = 2'd3;
      repeat ($urandom_range(1, 2)) begin
        @(negedge clk); cycle = 2'd0;
      end
    end
  end

  always @(posedge clk) begin
    if (cycle == 2'd1) tickCount <= tickCount + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pot_valid / round_done strobe pops one expected event
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = '0;
      prevRound = 1'b0;
    end else begin
      if (prevValid != 0) checkOutput("pot_valid one clk wide", 32'(pot_valid), 32'd0);
      if (prevRound) checkOutput("round_done one clk wide", 32'(round_done), 32'd0);
      if (pot_valid != 0 && prevValid == 0) begin
        if (sbQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected pot_valid: got %b, required no strobe", pot_valid);
        end else begin
          monEvt = sbQ.pop_front();
          if (monEvt.isRound) begin
            checks++; errors++;
            $display("[TB] FAIL event order: got pot_valid %b, required round_done", pot_valid);
          end else begin
            checkOutput("pot_valid channel", 32'(pot_valid), 32'(1 << monEvt.ch));
            checkOutput($sformatf("pot[%0d] value", monEvt.ch), 32'(pot[monEvt.ch]), 32'(monEvt.val));
          end
        end
      end
      if (round_done && !prevRound) begin
        if (sbQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected round_done: got 1, required 0");
        end else begin
          monEvt = sbQ.pop_front();
          if (!monEvt.isRound) begin
            checks++; errors++;
            $display("[TB] FAIL event order: got round_done, required pot_valid for channel %0d", monEvt.ch);
          end else begin
            checks++;
          end
        end
      end
      prevValid = pot_valid;
      prevRound = round_done;
      if (muxCheckOn && !muxAllowed[mux_sel]) muxViol++;
    end
  end

  task automatic clearModel();
    for (int i = 0; i < 4; i++) begin
      potModel[i]    = 8'h00;
      primedModel[i] = 0;
    end
    sbQ.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    enable  = 1'b0;
    charged = 1'b0;
    rst_n   = 1'b0;
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitTicks(input int n);
    int t;
    t = tickCount;
    while (tickCount - t < n) @(negedge clk);
  endtask

  // One measurement: expect channel ch, make the comparator trip k measure ticks in
  task automatic applyStimulus(input int ch, input int k, input bit keepHigh, input bit lastInRound);
    int   waitClks;
    int   t0;
    int   val;
    int   avg;
    bit   raised;
    evt_t e;
    waitClks = 0;
    do begin
      @(negedge clk);
      waitClks++;
    end while (discharge !== 1'b0 && waitClks < 4000);
    if (discharge !== 1'b0) begin
      checks++; errors++;
      $display("[TB] FAIL measure start timeout ch %0d: got discharge %b, required 0", ch, discharge);
      return;
    end
    checkOutput("mux_sel at measure start", 32'(mux_sel), 32'(ch));
    val = (k > 255) ? 255 : k;
`ifdef SID_POT_SCHED_AVG_EN
    if (primedModel[ch]) begin
      avg = (int'(potModel[ch]) + val + 1) / 2;
      potModel[ch] = 8'(avg);
    end else begin
      potModel[ch] = 8'(val);
    end
    primedModel[ch] = 1;
`else
    avg = 0;
    potModel[ch] = 8'(val + avg);
`endif
    e.isRound = 0; e.ch = ch; e.val = potModel[ch];
    sbQ.push_back(e);
    if (lastInRound) begin
      e.isRound = 1; e.ch = -1; e.val = 8'h00;
      sbQ.push_back(e);
    end
    t0 = tickCount;
    raised = 0;
    forever begin
      if (!raised && (tickCount - t0) >= k) begin
        charged = 1'b1;
        raised  = 1;
      end
      @(negedge clk);
      if (discharge === 1'b1) break;
      if (tickCount - t0 > 300) begin
        checks++; errors++;
        $display("[TB] FAIL measure end timeout ch %0d: got %0d ticks, required %0d", ch, tickCount - t0, val + 1);
        break;
      end
    end
    checkOutput("discharge low ticks", 32'(tickCount - t0), 32'(val + 1));
    if (!keepHigh) charged = 1'b0;
  endtask

  task automatic finishTest();
    enable = 1'b0;
    waitTicks(10);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("pot[%0d] retained", i), 32'(pot[i]), 32'(potModel[i]));
  endtask

  // mode 0: random trip time, 1: never charged, 2: charged stuck high
  task automatic runRounds(input logic [3:0] mask, input int count, input int mode);
    int chans[$];
    int idx;
    int k;
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
    @(negedge clk);
    ch_mask = mask;
    enable  = 1'b1;
    if (mode == 2) charged = 1'b1;
    idx = 0;
    for (int m = 0; m < count; m++) begin
      case (mode)
        0:       k = $urandom_range(0, 300);
        1:       k = 300;
        default: k = 0;
      endcase
      applyStimulus(chans[idx], k, mode == 2, idx == chans.size() - 1);
      idx = (idx + 1) % chans.size();
    end
    finishTest();
    charged = 1'b0;
  endtask

  initial begin
    int lowCnt;
    int t;
    int waitClks;
    clearModel();
    #2;
    checkOutput("reset discharge", 32'(discharge), 32'd1);
    checkOutput("reset mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("reset pot", 32'(pot), 32'd0);
    checkOutput("reset pot_valid", 32'(pot_valid), 32'd0);
    checkOutput("reset round_done", 32'(round_done), 32'd0);
    doReset();

    $display("[TB] single channel, trip after 100 measure ticks");
    @(negedge clk);
    ch_mask = 4'b0001;
    enable  = 1'b1;
    applyStimulus(0, 100, 0, 1);
    finishTest();
    checkOutput("pot[0] after 100 ticks", 32'(pot[0]), 32'h64);

    $display("[TB] comparator stuck low, all channels");
    doReset();
    runRounds(4'b1111, 5, 1);

    $display("[TB] comparator stuck high, mask 1010");
    doReset();
    @(negedge clk);
    charged = 1'b1;
    ch_mask = 4'b1010;
    enable  = 1'b1;
    applyStimulus(1, 0, 1, 0);
    muxCheckOn = 1;
    applyStimulus(3, 0, 1, 1);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(3, 0, 1, 1);
    finishTest();
    muxCheckOn = 0;
    charged = 1'b0;
    checkOutput("mux_sel only 1 or 3", 32'(muxViol), 32'd0);

    $display("[TB] enable dropped during discharge of channel 2");
    doReset();
    @(negedge clk);
    ch_mask = 4'b0111;
    enable  = 1'b1;
    applyStimulus(0, $urandom_range(0, 300), 0, 0);
    applyStimulus(1, $urandom_range(0, 300), 0, 0);
    waitTicks(50);
    enable = 1'b0;
    waitTicks(1);
    checkOutput("discharge after abort", 32'(discharge), 32'd1);
    lowCnt = 0;
    t = tickCount;
    while (tickCount - t < 300) begin
      @(negedge clk);
      if (discharge !== 1'b1) lowCnt++;
    end
    checkOutput("discharge held while idle", 32'(lowCnt), 32'd0);
    enable = 1'b1;
    applyStimulus(0, $urandom_range(0, 300), 0, 0);
    finishTest();

    $display("[TB] back-to-back samples 0x40 then 0x81 on channel 0");
    doReset();
    @(negedge clk);
    ch_mask = 4'b0001;
    enable  = 1'b1;
    applyStimulus(0, 8'h40, 0, 1);
    checkOutput("pot[0] first sample", 32'(pot[0]), 32'h40);
    applyStimulus(0, 8'h81, 0, 1);
`ifdef SID_POT_SCHED_AVG_EN
    checkOutput("pot[0] averaged", 32'(pot[0]), 32'h61);
`else
    checkOutput("pot[0] raw second", 32'(pot[0]), 32'h81);
`endif

    $display("[TB] asynchronous reset in the middle of a measurement");
    waitClks = 0;
    do begin
      @(negedge clk);
      waitClks++;
    end while (discharge !== 1'b0 && waitClks < 4000);
    checkOutput("measure reached before reset", 32'(discharge), 32'd0);
    waitTicks(20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset discharge", 32'(discharge), 32'd1);
    checkOutput("async reset mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("async reset pot", 32'(pot), 32'd0);
    checkOutput("async reset pot_valid", 32'(pot_valid), 32'd0);
    checkOutput("async reset round_done", 32'(round_done), 32'd0);
    enable = 1'b0;
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] randomized masks and trip times");
    for (int r = 0; r < 2; r++) begin
      doReset();
      runRounds(4'($urandom_range(1, 15)), 4, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
